// File: rtl/address_latch_incdec.sv
// Address latch with a registered +1/-1/+0 stage that drives the CPU address pins
// and returns the adjusted value to the register file for PC/SP/BC/HL write-back.
module address_latch_incdec #(
  parameter int unsigned     AW         = 16,
  parameter logic [AW-1:0]   RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            nhold_clk_wait,
  input  logic [AW/2-1:0] db_hi_as_in,
  input  logic [AW/2-1:0] db_lo_as_in,
  input  logic            ctl_al_we,
  input  logic            ctl_al_hi_ff,
  input  logic            ctl_inc_cy,
  input  logic            ctl_inc_dec,
  input  logic            ctl_apin_mux,
  input  logic            ctl_bus_inc_oe,
  output logic [AW/2-1:0] db_hi_as_out,
  output logic [AW/2-1:0] db_lo_as_out,
  output logic            as_oe,
  output logic [AW-1:0]   abus,
  output logic            address_is_zero
);

  logic [AW-1:0] latch_q, latch_d;
  logic [AW-1:0] result_q, result_d;
  logic [AW-1:0] abus_q, abus_d;
  logic          zero_q, zero_d;
  logic [AW-1:0] adjust;

  // The inc/dec stage works on the value already held in the latch, giving one
  // cycle of latency between a bus load and its adjusted result.
  always_comb begin
    latch_d = latch_q;
    if (ctl_al_we) begin
      latch_d = {(ctl_al_hi_ff ? {(AW/2){1'b1}} : db_hi_as_in), db_lo_as_in};
    end

    adjust = '0;
    if (ctl_inc_cy) begin
      adjust = ctl_inc_dec ? {AW{1'b1}} : AW'(1);
    end

    result_d = latch_q + adjust;
    zero_d   = (result_d == '0);
    abus_d   = ctl_apin_mux ? result_d : latch_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q  <= RESET_ADDR;
      result_q <= RESET_ADDR;
      abus_q   <= RESET_ADDR;
      zero_q   <= (RESET_ADDR == '0);
    end else if (nhold_clk_wait) begin
      latch_q  <= latch_d;
      result_q <= result_d;
      abus_q   <= abus_d;
      zero_q   <= zero_d;
    end
  end

  // Loading the latch while driving the bus would loop the result back onto its
  // own source, so a simultaneous load suppresses the drive.
  assign as_oe           = ctl_bus_inc_oe & ~ctl_al_we;
  assign db_hi_as_out    = result_q[AW-1:AW/2];
  assign db_lo_as_out    = result_q[AW/2-1:0];
  assign abus            = abus_q;
  assign address_is_zero = zero_q;

endmodule

// File: tb/tb_address_latch_incdec.sv
// Directed self-checking bench for address_latch_incdec: reset, inc/dec with wrap,
// hi-FF page forcing, wait-state hold, write-back enable and back-to-back pipelining.
module tb_address_latch_incdec;

  logic        clk;
  logic        reset;
  logic        nhold_clk_wait;
  logic [7:0]  db_hi_as_in;
  logic [7:0]  db_lo_as_in;
  logic        ctl_al_we;
  logic        ctl_al_hi_ff;
  logic        ctl_inc_cy;
  logic        ctl_inc_dec;
  logic        ctl_apin_mux;
  logic        ctl_bus_inc_oe;
  logic [7:0]  db_hi_as_out;
  logic [7:0]  db_lo_as_out;
  logic        as_oe;
  logic [15:0] abus;
  logic        address_is_zero;

  int compared = 0;
  int mismatched = 0;

  address_latch_incdec dut (
    .clk             (clk),
    .reset           (reset),
    .nhold_clk_wait  (nhold_clk_wait),
    .db_hi_as_in     (db_hi_as_in),
    .db_lo_as_in     (db_lo_as_in),
    .ctl_al_we       (ctl_al_we),
    .ctl_al_hi_ff    (ctl_al_hi_ff),
    .ctl_inc_cy      (ctl_inc_cy),
    .ctl_inc_dec     (ctl_inc_dec),
    .ctl_apin_mux    (ctl_apin_mux),
    .ctl_bus_inc_oe  (ctl_bus_inc_oe),
    .db_hi_as_out    (db_hi_as_out),
    .db_lo_as_out    (db_lo_as_out),
    .as_oe           (as_oe),
    .abus            (abus),
    .address_is_zero (address_is_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic load(input logic [15:0] value);
    db_hi_as_in = value[15:8];
    db_lo_as_in = value[7:0];
  endtask

  initial begin
    reset = 1'b1; nhold_clk_wait = 1'b1; load(16'h0000);
    ctl_al_we = 0; ctl_al_hi_ff = 0; ctl_inc_cy = 0; ctl_inc_dec = 0;
    ctl_apin_mux = 0; ctl_bus_inc_oe = 0;

    #3;
    check("reset_abus", abus, 16'h0000);
    check("reset_zero", 16'(address_is_zero), 16'h1);
    check("reset_as_oe", 16'(as_oe), 16'h0);
    check("reset_result", {db_hi_as_out, db_lo_as_out}, 16'h0000);
    tick();
    reset = 1'b0;

    // Increment 8241 -> 8242, pins show the result.
    load(16'h8241); ctl_al_we = 1; ctl_inc_cy = 1; ctl_inc_dec = 0; ctl_apin_mux = 1;
    tick();
    ctl_al_we = 0;
    tick();
    check("inc_result", {db_hi_as_out, db_lo_as_out}, 16'h8242);
    check("inc_abus", abus, 16'h8242);
    check("inc_zero", 16'(address_is_zero), 16'h0);

    // FFFF + 1 wraps to zero.
    load(16'hFFFF); ctl_al_we = 1;
    tick();
    ctl_al_we = 0;
    tick();
    check("wrap_inc_result", {db_hi_as_out, db_lo_as_out}, 16'h0000);
    check("wrap_inc_zero", 16'(address_is_zero), 16'h1);

    // 0000 - 1 wraps to FFFF.
    load(16'h0000); ctl_al_we = 1; ctl_inc_dec = 1;
    tick();
    ctl_al_we = 0;
    tick();
    check("wrap_dec_result", {db_hi_as_out, db_lo_as_out}, 16'hFFFF);
    check("wrap_dec_zero", 16'(address_is_zero), 16'h0);

    // 0001 - 1 reaches zero (BC exhausted).
    load(16'h0001); ctl_al_we = 1;
    tick();
    ctl_al_we = 0;
    tick();
    check("dec_to_zero_result", {db_hi_as_out, db_lo_as_out}, 16'h0000);
    check("dec_to_zero_flag", 16'(address_is_zero), 16'h1);

    // High byte forced to FF, pins from the latch.
    load(16'hAD38); ctl_al_we = 1; ctl_al_hi_ff = 1; ctl_inc_cy = 0; ctl_inc_dec = 0;
    ctl_apin_mux = 0;
    tick();
    check("hiff_abus", abus, 16'hFF38);
    ctl_al_we = 0; ctl_al_hi_ff = 0;
    tick();
    check("hiff_result", {db_hi_as_out, db_lo_as_out}, 16'hFF38);

    // hi_ff alone does not touch the latch.
    load(16'h1111); ctl_al_hi_ff = 1;
    tick();
    check("hiff_ignored_abus", abus, 16'hFF38);
    ctl_al_hi_ff = 0;

    // Wait stretch: three frozen edges while a load is requested.
    nhold_clk_wait = 0; load(16'h1234); ctl_al_we = 1; ctl_inc_cy = 1;
    tick(); tick(); tick();
    check("hold_abus", abus, 16'hFF38);
    check("hold_result", {db_hi_as_out, db_lo_as_out}, 16'hFF38);
    check("hold_zero", 16'(address_is_zero), 16'h0);
    nhold_clk_wait = 1;
    tick();
    check("release_abus", abus, 16'h1234);
    check("release_result", {db_hi_as_out, db_lo_as_out}, 16'hFF39);
    ctl_al_we = 0;
    tick();
    check("release_inc_result", {db_hi_as_out, db_lo_as_out}, 16'h1235);

    // Write-back drive, then suppressed by a simultaneous load.
    ctl_bus_inc_oe = 1; ctl_inc_cy = 0;
    #1;
    check("wb_as_oe", 16'(as_oe), 16'h1);
    check("wb_bus", {db_hi_as_out, db_lo_as_out}, 16'h1235);
    ctl_al_we = 1;
    #1;
    check("wb_suppressed", 16'(as_oe), 16'h0);

    // Back-to-back loads with increment.
    ctl_bus_inc_oe = 0; ctl_inc_cy = 1; ctl_apin_mux = 1;
    load(16'h0100);
    tick();
    load(16'h0200);
    tick();
    check("b2b_result0", {db_hi_as_out, db_lo_as_out}, 16'h0101);
    check("b2b_abus0", abus, 16'h0101);
    load(16'h0300);
    tick();
    check("b2b_result1", {db_hi_as_out, db_lo_as_out}, 16'h0201);
    ctl_al_we = 0;
    tick();
    check("b2b_result2", {db_hi_as_out, db_lo_as_out}, 16'h0301);

    // Asynchronous reset in the middle of a cycle discards the in-flight value.
    load(16'h5555); ctl_al_we = 1;
    #2;
    reset = 1'b1;
    #1;
    check("midreset_abus", abus, 16'h0000);
    check("midreset_zero", 16'(address_is_zero), 16'h1);
    check("midreset_as_oe", 16'(as_oe), 16'h0);
    check("midreset_result", {db_hi_as_out, db_lo_as_out}, 16'h0000);
    tick();
    reset = 1'b0; ctl_al_we = 0; ctl_inc_cy = 0;
    tick();
    check("postreset_result", {db_hi_as_out, db_lo_as_out}, 16'h0000);
    check("postreset_abus", abus, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
